// File: rtl/icache_refill_pkg.sv
// Shared mem-ctrl definitions for the instruction-side refill engine.
package icache_refill_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int ROW_WIDTH      = 8 * LINE_BYTES;
  localparam int OFFSET_BITS    = $clog2(LINE_BYTES);
  localparam int RAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : icache_refill_pkg

// File: rtl/icache_refill.sv
// I-cache miss engine: fetches one aligned line byte-by-byte from the shared
// RAM port and returns it to ifetch as a single row with a one-cycle pulse.
module icache_refill #(
  parameter int LINE_BYTES = icache_refill_pkg::LINE_BYTES,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic [ADDR_WIDTH-1:0]   missing_PC,
  input  logic                    missing_config,
  output logic [8*LINE_BYTES-1:0] return_row,
  output logic                    return_config,
  output logic                    bus_req,
  input  logic                    bus_grant,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic [7:0]              mem_din
);
  import icache_refill_pkg::*;

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int CNT_BITS = OFF_BITS + 1;
  localparam logic [CNT_BITS-1:0]   LINE_CNT = CNT_BITS'(LINE_BYTES);
  localparam logic [CNT_BITS-1:0]   CNT_ONE  = CNT_BITS'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_BITS-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_BITS-1:0]     recv_cnt_q, recv_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [8*LINE_BYTES-1:0] row_q, row_d;

  // Next-state, counter, byte-lane and output decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    inflight_d    = 1'b0;
    row_d         = row_q;
    mem_a         = '0;
    bus_req       = 1'b0;
    return_config = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rdy && missing_config) begin
          base_d      = missing_PC & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_grant) state_d = READ;
      end
      READ: begin
        bus_req = 1'b1;
        // Offset only fills the cleared low bits, so the OR never carries
        // out of the line, even for the top line of the address space.
        if (rdy && bus_grant && (issue_cnt_q < LINE_CNT)) begin
          mem_a       = base_q | ADDR_WIDTH'(issue_cnt_q[OFF_BITS-1:0]);
          issue_cnt_d = issue_cnt_q + CNT_ONE;
          inflight_d  = 1'b1;
        end
        // Data for last cycle's address arrives now; RAM is not gated by rdy.
        if (inflight_q) begin
          row_d[{recv_cnt_q[OFF_BITS-1:0], 3'b000} +: 8] = mem_din;
          recv_cnt_d = recv_cnt_q + CNT_ONE;
          if (recv_cnt_q == LINE_CNT - CNT_ONE) state_d = DONE;
        end
      end
      DONE: begin
        return_config = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and assembled row; reset drops any partial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      // NOTE: the row is a plain register bank, not a RAM, so it can be
      // reset; ifetch expects it to read zero out of reset.
      row_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      inflight_q  <= inflight_d;
      row_q       <= row_d;
    end
  end

  assign return_row = row_q;
  assign mem_wr     = 1'b0;

endmodule : icache_refill

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: table-driven directed misses plus
// randomized stall patterns, checked against a cycle-level protocol model.
module tb_icache_refill;

  localparam int LB = 64;
  localparam int AW = 32;
  localparam int RW = 8 * LB;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst_n, rdy, missing_config, bus_grant;
  logic [AW-1:0] missing_PC, mem_a;
  logic [RW-1:0] return_row;
  logic          return_config, bus_req, mem_wr;
  logic [7:0]    mem_din;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int expected_pulses = 0;

  bit g_pat [MAXC];
  bit r_pat [MAXC];

  typedef struct {
    logic [31:0] pc;
    int          gdelay;
    int          g_lo, g_len;
    int          r_lo, r_len;
    int          abort_at;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  icache_refill #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .missing_PC    (missing_PC),
    .missing_config(missing_config),
    .return_row    (return_row),
    .return_config (return_config),
    .bus_req       (bus_req),
    .bus_grant     (bus_grant),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .mem_din       (mem_din)
  );

  // RAM contents: byte at 0x1000+k is k+0x10; other regions differ.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return (a[7:0] + 8'h10) ^ (a[15:8] - 8'h10) ^ a[23:16] ^ a[31:24];
  endfunction

  // Byte-wide RAM with one cycle of read latency.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  // Count return pulses independently of the stimulus tasks.
  always @(negedge clk) if (rst_n && return_config) pulses++;

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_windows(input int g_lo, input int g_len,
                             input int r_lo, input int r_len);
    for (int i = 0; i < MAXC; i++) begin
      g_pat[i] = !(i >= g_lo && i < g_lo + g_len);
      r_pat[i] = !(i >= r_lo && i < r_lo + r_len);
    end
  endtask

  // One miss as seen by ifetch; lat = cycles from bus_req rising to the pulse.
  task automatic do_miss(input logic [31:0] pc, input int gdelay,
                         input int abort_at, output int lat);
    logic [31:0] base;
    logic [RW-1:0] exp_row;
    int issued, last, p0;
    bit done;
    base = pc & ~32'(LB - 1);
    for (int k = 0; k < LB; k++) exp_row[8*k +: 8] = ram_byte(base + 32'(k));
    issued = 0; last = -1; done = 1'b0; lat = -1;
    p0 = pulses;

    // IDLE cycle: raise the request.
    @(negedge clk);
    missing_PC = pc; missing_config = 1'b1; bus_grant = 1'b0; rdy = 1'b1;
    #1;
    check("idle_bus_req", RW'(bus_req), RW'(0));
    check("idle_mem_a", RW'(mem_a), RW'(0));

    // REQ cycles: grant withheld for gdelay cycles; PC changes must be ignored.
    for (int c = 0; c <= gdelay; c++) begin
      @(negedge clk);
      bus_grant = (c == gdelay);
      missing_PC = $urandom;
      #1;
      check("req_bus_req", RW'(bus_req), RW'(1));
      check("req_mem_a", RW'(mem_a), RW'(0));
    end

    // READ cycles until the return pulse.
    for (int r = 0; r < MAXC && !done; r++) begin
      @(negedge clk);
      bus_grant = g_pat[r]; rdy = r_pat[r];
      #1;
      if (last >= 0 && r == last + 2) begin
        check("ret_cfg", RW'(return_config), RW'(1));
        check("done_bus_req", RW'(bus_req), RW'(0));
        check("ret_row", return_row, exp_row);
        check("pulse_count", RW'(pulses), RW'(p0 + 1));
        missing_config = 1'b0;
        lat = gdelay + 1 + r;
        done = 1'b1;
      end else begin
        check("ret_cfg_low", RW'(return_config), RW'(0));
        check("read_bus_req", RW'(bus_req), RW'(1));
        if (rdy && bus_grant && issued < LB) begin
          check("mem_a", RW'(mem_a), RW'(base + 32'(issued)));
          issued++;
          if (issued == LB) last = r;
        end else begin
          check("mem_a_stall", RW'(mem_a), RW'(0));
        end
        if (abort_at >= 0 && issued == abort_at + 1) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_bus_req", RW'(bus_req), RW'(0));
          check("rst_ret_cfg", RW'(return_config), RW'(0));
          check("rst_mem_a", RW'(mem_a), RW'(0));
          check("rst_row", return_row, RW'(0));
          missing_config = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: got no return_config expected pulse for pc %0h", pc);
      missing_config = 1'b0;
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h0000_1024, 0,  0, 0,  0, 0, -1, 66};  // basic refill
    vecs[1] = '{32'h0000_1024, 5,  0, 0,  0, 0, -1, 71};  // grant delay
    vecs[2] = '{32'h0000_1000, 0, 21, 3, 44, 2, -1, 71};  // mid-burst stalls
    vecs[3] = '{32'h0000_1000, 0,  0, 0,  0, 0, 30, -1};  // reset at byte 30
    vecs[4] = '{32'h0000_2000, 0,  0, 0,  0, 0, -1, 66};  // refill after reset
    vecs[5] = '{32'h0000_3040, 0,  0, 0,  0, 0, -1, 66};  // back-to-back

    rst_n = 1'b0; rdy = 1'b0; missing_config = 1'b0; bus_grant = 1'b0;
    missing_PC = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_bus_req", RW'(bus_req), RW'(0));
    check("reset_ret_cfg", RW'(return_config), RW'(0));
    check("reset_mem_a", RW'(mem_a), RW'(0));
    check("reset_mem_wr", RW'(mem_wr), RW'(0));
    check("reset_row", return_row, RW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_windows(vecs[i].g_lo, vecs[i].g_len, vecs[i].r_lo, vecs[i].r_len);
      do_miss(vecs[i].pc, vecs[i].gdelay, vecs[i].abort_at, lat);
      if (vecs[i].abort_at < 0) begin
        expected_pulses++;
        check("latency", RW'(lat), RW'(vecs[i].exp_lat));
      end
    end

    // Top-of-memory line, then randomized lines with random stalls.
    set_windows(0, 0, 0, 0);
    do_miss(32'hFFFF_FFF8, 0, -1, lat);
    expected_pulses++;
    check("top_latency", RW'(lat), RW'(66));

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < MAXC; i++) begin
        g_pat[i] = ($urandom_range(0, 3) != 0);
        r_pat[i] = ($urandom_range(0, 3) != 0);
      end
      do_miss($urandom, $urandom_range(0, 3), -1, lat);
      expected_pulses++;
    end

    repeat (3) @(negedge clk);
    #1;
    check("final_pulses", RW'(pulses), RW'(expected_pulses));
    check("final_bus_req", RW'(bus_req), RW'(0));
    check("final_mem_wr", RW'(mem_wr), RW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_icache_refill

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Instruction-side miss engine inside mem-ctrl, directly upstream of ifetch.
- Accepts a miss request (missing_PC, missing_config) from ifetch and reads the aligned 64-byte line from the byte-wide RAM port, one byte per cycle.
- Assembles the bytes into a 512-bit row, returns it with a one-cycle return_config pulse, then releases the bus.
- Shares the RAM port with the data side through an external non-preemptive arbiter (bus_req/bus_grant).

Parameters:
- LINE_BYTES, 64: bytes per I-cache line; power of two; row width is 8*LINE_BYTES.
- ADDR_WIDTH, 32: address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low, no new RAM address is issued.
- missing_PC  in  ADDR_WIDTH  miss address from ifetch; any byte of the line.
- missing_config  in  1  miss request level; ifetch holds it high until it samples return_config.
- return_row  out  8*LINE_BYTES  assembled line.
- return_config  out  1  one-cycle pulse; return_row is valid in the same cycle.
- bus_req  out  1  RAM port request to the arbiter.
- bus_grant  in  1  arbiter grant; this block drives the RAM only while it is high.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  RAM write enable; constant 0 (read-only engine).
- mem_din  in  8  RAM read data; valid one cycle after its address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters cleared.
  - return_config=0, bus_req=0, mem_a=0, mem_wr=0, return_row=0.
  - A reset during a burst discards the partial line; no return is produced.
- Line base: line_base = missing_PC with log2(LINE_BYTES) LSBs cleared. It is latched on leaving IDLE, and later changes of missing_PC are ignored.
- States:
  - IDLE: if rdy and missing_config, latch line_base and go to REQ.
  - REQ: bus_req=1; when bus_grant=1, go to READ.
  - READ: bus_req=1.
  - DONE: return_config=1 for exactly one cycle; bus_req=0; next state IDLE.
- Issue rule in READ: when rdy and bus_grant and issue_cnt<LINE_BYTES, then:
  - mem_a = line_base + issue_cnt;
  - issue_cnt increments;
  - a one-cycle in-flight flag is set.
  Otherwise mem_a=0 and no issue occurs.
- Capture rule: in the cycle after an issue, write mem_din into return_row[8*recv_cnt+7 : 8*recv_cnt] and increment recv_cnt. Capture happens regardless of rdy or bus_grant, because the RAM is not gated by rdy.
- Byte order: little-endian. Byte base+k lands in bits [8k+7:8k], so instruction word j occupies [32j+31:32j], matching ifetch slicing.
- End of burst: when recv_cnt reaches LINE_BYTES, go to DONE.
  - Minimum latency from grant: LINE_BYTES+1 cycles in READ, then the DONE cycle.
  - Total is 66 cycles from the first grant cycle to return_config with no stalls.
- Stalls:
  - bus_grant or rdy low mid-burst pauses issuing.
  - issue_cnt/recv_cnt are retained, and issuing resumes at the next unissued byte. No byte is skipped or duplicated.
- return_row holds its value after DONE until the next capture.
- missing_config is sampled only in IDLE. The cycle after DONE is IDLE, and ifetch has dropped the request by then, so one miss cannot retrigger twice.
- Counter widths are log2(LINE_BYTES)+1 bits; line_base + offset never carries out of the line.
- Address wrap: a line at 0xFFFFFFC0 issues addresses 0xFFFFFFC0..0xFFFFFFFF with no wrap.

Decomposition:
- Shared mem-ctrl package holds:
  - state enum (IDLE, REQ, READ, DONE);
  - LINE_BYTES, ROW_WIDTH = 8*LINE_BYTES, OFFSET_BITS = log2(LINE_BYTES);
  - RAM read latency constant (1).
- No sub-module: counters, FSM and byte-lane write all fit in one block.
- The arbiter stays in mem-ctrl top.

Test Plan:
- Basic refill:
  - Stimulus: RAM preloaded with byte k = k+0x10 at 0x1000..0x103F; missing_PC=0x1024 with missing_config=1; grant held.
  - Response: mem_a sweeps 0x1000..0x103F; return_config pulses once 66 cycles after grant; return_row[7:0]=0x10 and return_row[511:504]=0x4F.
- Grant delay:
  - Stimulus: bus_grant held low for 5 cycles after bus_req rises.
  - Response: no address is driven while grant is low; the row is identical to the unstalled case; return_config is delayed by 5 cycles.
- Mid-burst stall:
  - Stimulus: drop bus_grant for 3 cycles after byte 20 issues, and drop rdy for 2 cycles at byte 40.
  - Response: byte 20 is still captured; issuing resumes at 21 and at 41; the row has no duplicated or missing bytes.
- Async reset mid-burst:
  - Stimulus: pull rst_n low at byte 30.
  - Response: bus_req=0 and return_config=0 immediately; IDLE after release; a new miss at 0x2000 then completes correctly.
- Back-to-back misses:
  - Stimulus: ifetch model drops missing_config on the return_config edge, then raises it 1 cycle later with 0x3040.
  - Response: exactly two return_config pulses; the second row comes from 0x3040..0x307F.
- Top-of-memory line:
  - Stimulus: missing_PC=0xFFFFFFF8.
  - Response: line_base=0xFFFFFFC0; the last mem_a is 0xFFFFFFFF; the row is correct.
